// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared constants and state type for the shift arbiter
package shift_ctrl_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with last-grant pointer
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       idx
);

    logic r_ptr;
    logic w_any;

    assign w_any = |req;

    // On contention the requester that did not win last time is chosen.
    always_comb begin
        idx = req[1];
        if (req == 2'b11)
            idx = ~r_ptr;
        gnt = (en && w_any) ? (2'b01 << idx) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= 1'b1;
        else if (en && w_any)
            r_ptr <= idx;
    end

endmodule

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - shares one shift register between two requesters
import shift_ctrl_pkg::*;

module shift_arbiter #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic             r_l0,
    input  logic             r_l1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [CNT_W-1:0] cnt0,
    input  logic [CNT_W-1:0] cnt1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             owner,
    output logic [WIDTH-1:0] q
);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic             r_dir;
    logic [CNT_W-1:0] r_remaining;
    logic             r_owner;

    logic             w_en;
    logic [1:0]       w_gnt;
    logic             w_idx;
    logic [CNT_W-1:0] w_cnt_sel;
    logic [CNT_W-1:0] w_cnt_clamp;

    // Reset takes priority over a grant in the same cycle.
    assign w_en = (r_state == ST_IDLE) && !rst;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (w_en),
        .gnt (w_gnt),
        .idx (w_idx)
    );

    assign w_cnt_sel   = w_idx ? cnt1 : cnt0;
    assign w_cnt_clamp = (w_cnt_sel > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : w_cnt_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_q         <= '0;
            r_dir       <= DIR_LEFT;
            r_remaining <= '0;
            r_owner     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_q         <= w_idx ? din1 : din0;
                        r_dir       <= w_idx ? r_l1 : r_l0;
                        r_remaining <= w_cnt_clamp;
                        r_owner     <= w_idx;
                        r_state     <= (w_cnt_clamp != '0) ? ST_SHIFT : ST_DONE;
                    end
                end
                ST_SHIFT: begin
                    r_q <= (r_dir == DIR_RIGHT) ? {1'b0, r_q[WIDTH-1:1]}
                                                : {r_q[WIDTH-2:0], 1'b0};
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == CNT_W'(1))
                        r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt   = w_gnt;
    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign owner = r_owner;
    assign q     = r_q;

endmodule
